branch_rs_multi: RTL and testbench
==================================

// Module: branch_rs_multi
// PURPOSE
//  Multi-entry, parametrised branch reservation station between dispatcher and branch executor.
//  Holds up to DEPTH branch ops and snoops ALU and LS result broadcasts to resolve operand tags.
//  Each cycle it issues the oldest fully-ready entry to the branch executor.
//  Adds bypass when idle, same-cycle alloc wakeup, full/occupancy reporting and misprediction flush.
// PARAMETERS
//  DEPTH    4   entries (>=2)
//  DATA_W   32  operand/imm width
//  ADDR_W   32  PC width
//  TAG_W    4   rename tag width
//  OP_W     6   opcode width
//  TAG_FREE 0   tag value meaning "operand present"
//  NOP_OP   0   opcode driven when idle
// PORTS
//  clk         in  1                  clock, rising edge
//  rst         in  1                  asynchronous reset, active-high
//  rdy         in  1                  global enable; low = hold all state
//  flush       in  1                  squash all entries (mispredict)
//  alu_wrt_en  in  1                  ALU broadcast valid
//  alu_tag     in  TAG_W              ALU broadcast tag
//  alu_data    in  DATA_W             ALU broadcast data
//  ls_wrt_en   in  1                  LS broadcast valid
//  ls_tag      in  TAG_W              LS broadcast tag
//  ls_data     in  DATA_W             LS broadcast data
//  alloc_en    in  1                  dispatcher pushes one branch
//  alloc_opnd_o/alloc_opnd_t in DATA_W   operand values
//  alloc_tag_o/alloc_tag_t   in TAG_W    operand tags
//  alloc_op    in  OP_W               opcode
//  alloc_imm   in  DATA_W             immediate
//  alloc_pc    in  ADDR_W             branch PC
//  full        out 1                  registered: count==DEPTH
//  count       out $clog2(DEPTH+1)    registered valid entry count
//  work_en     out 1                  issue strobe to branch executor
//  operand_o/operand_t out DATA_W     issued operands
//  imm         out DATA_W             issued immediate
//  op_code     out OP_W               issued opcode
//  pc          out ADDR_W             issued PC
// BEHAVIOUR
//  Reset: all entries invalid, count=0, full=0, work_en=0, operands/imm/pc=0, op_code=NOP_OP.
//  rdy=0: every register holds (incl. work_en and outputs); broadcasts that cycle are lost.
//  Wakeup (comb, per operand): tag!=TAG_FREE and matches alu_tag (alu_wrt_en) or ls_tag
//   (ls_wrt_en) -> nxt data=broadcast, nxt tag=TAG_FREE; ALU wins if both match. Stored entries
//   latch nxt values each enabled cycle; alloc operands pass through same wakeup before storing.
//  Entry ready = valid and both nxt tags == TAG_FREE (wakeup and issue in same cycle).
//  Age: entry age field 0..DEPTH-1, 0 = oldest. Issue picks ready entry with smallest age;
//   on issue, all entries with larger age decrement. New entry gets age = count after issue.
//  Issue: registered, 1-cycle latency; work_en=1 one cycle with nxt operand values; entry freed.
//   No issue -> work_en=0, op_code=NOP_OP, data outputs=0.
//  Bypass: alloc_en, alloc operands ready after wakeup, and no stored entry ready -> alloc goes
//   straight to outputs next cycle, never stored. Otherwise alloc is stored in lowest free slot.
//  Full: full is pre-issue state; alloc_en with full=1 and no bypass is dropped (dispatcher must
//   not do this), even if an entry issues that cycle. Bypass while full is legal.
//  count: count_next = count + stored_alloc - issued_from_entry; never wraps.
//  flush (sync, above all but rst, needs rdy): all entries invalid, count=0, work_en=0, outputs
//   idle; alloc/bypass in the flush cycle is discarded.
//  Reset mid-operation: asynchronous, immediately forces reset values.
// TESTING
//  Empty, alloc tags FREE, opnd 5/7, pc=0x100 -> next cycle work_en=1, operands 5/7, count stays 0.
//  Alloc A tag_o=3, B tag_o=4; ALU bcast tag4=9 -> B issues 1 cycle later with operand_o=9, A stays.
//  Fill DEPTH entries all waiting tag 2; LS bcast tag2=0x55 -> issue in alloc order, one per cycle.
//  Alloc with tag_o=6 while ALU broadcasts tag6=0xAA same cycle, empty RS -> bypass, operand_o=0xAA.
//  count=3, flush with alloc_en=1 -> next cycle count=0, work_en=0, full=0; old tags ignored after.
//  full=1, alloc non-ready -> dropped, count stays DEPTH; rdy=0 pulse -> outputs and count hold.

Source files
------------

// File: rtl/branch_rs_multi.sv
// Branch reservation station with DEPTH entries.
// Holds dispatched branch ops until both operand tags resolve from ALU/LS
// result broadcasts, then issues the oldest ready entry to the branch
// executor with one cycle of latency. An alloc whose operands are already
// resolved bypasses the storage when no stored entry is ready to issue.
module branch_rs_multi #(
    parameter int                DEPTH    = 4,
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                TAG_W    = 4,
    parameter int                OP_W     = 6,
    parameter logic [TAG_W-1:0]  TAG_FREE = '0,
    parameter logic [OP_W-1:0]   NOP_OP   = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       alu_wrt_en,
    input  logic [TAG_W-1:0]           alu_tag,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       ls_wrt_en,
    input  logic [TAG_W-1:0]           ls_tag,
    input  logic [DATA_W-1:0]          ls_data,
    input  logic                       alloc_en,
    input  logic [DATA_W-1:0]          alloc_opnd_o,
    input  logic [DATA_W-1:0]          alloc_opnd_t,
    input  logic [TAG_W-1:0]           alloc_tag_o,
    input  logic [TAG_W-1:0]           alloc_tag_t,
    input  logic [OP_W-1:0]            alloc_op,
    input  logic [DATA_W-1:0]          alloc_imm,
    input  logic [ADDR_W-1:0]          alloc_pc,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       work_en,
    output logic [DATA_W-1:0]          operand_o,
    output logic [DATA_W-1:0]          operand_t,
    output logic [DATA_W-1:0]          imm,
    output logic [OP_W-1:0]            op_code,
    output logic [ADDR_W-1:0]          pc
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);

    // Entry storage
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][IDX_W-1:0]  e_age_q, e_age_d;
    logic [DEPTH-1:0][TAG_W-1:0]  e_tag_o_q, e_tag_o_d;
    logic [DEPTH-1:0][TAG_W-1:0]  e_tag_t_q, e_tag_t_d;
    logic [DEPTH-1:0][DATA_W-1:0] e_opnd_o_q, e_opnd_o_d;
    logic [DEPTH-1:0][DATA_W-1:0] e_opnd_t_q, e_opnd_t_d;
    logic [DEPTH-1:0][DATA_W-1:0] e_imm_q, e_imm_d;
    logic [DEPTH-1:0][OP_W-1:0]   e_op_q, e_op_d;
    logic [DEPTH-1:0][ADDR_W-1:0] e_pc_q, e_pc_d;

    // Registered status and issue outputs
    logic              full_q, full_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              work_en_q, work_en_d;
    logic [DATA_W-1:0] operand_o_q, operand_o_d;
    logic [DATA_W-1:0] operand_t_q, operand_t_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [OP_W-1:0]   op_code_q, op_code_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    // Post-wakeup views of entries and of the incoming alloc
    logic [DEPTH-1:0][TAG_W-1:0]  nxt_tag_o, nxt_tag_t;
    logic [DEPTH-1:0][DATA_W-1:0] nxt_opnd_o, nxt_opnd_t;
    logic [DEPTH-1:0]             ready;
    logic [TAG_W-1:0]             a_tag_o, a_tag_t;
    logic [DATA_W-1:0]            a_opnd_o, a_opnd_t;
    logic                         a_ready;

    // Selection results
    logic             any_ready;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] sel_age;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             bypass;
    logic             store;
    logic [CNT_W-1:0] cnt_after_issue;

    // Resolve one operand against the two broadcast buses; ALU has priority.
    function automatic logic [TAG_W+DATA_W-1:0] wake(
        input logic [TAG_W-1:0]  tag,
        input logic [DATA_W-1:0] data,
        input logic              a_en,
        input logic [TAG_W-1:0]  a_tg,
        input logic [DATA_W-1:0] a_dt,
        input logic              l_en,
        input logic [TAG_W-1:0]  l_tg,
        input logic [DATA_W-1:0] l_dt
    );
        logic [TAG_W+DATA_W-1:0] r;
        r = {tag, data};
        if (tag != TAG_FREE) begin
            if (a_en && (tag == a_tg)) begin
                r = {TAG_FREE, a_dt};
            end else if (l_en && (tag == l_tg)) begin
                r = {TAG_FREE, l_dt};
            end
        end
        return r;
    endfunction

    // Operand wakeup for stored entries and for the alloc port
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {nxt_tag_o[i], nxt_opnd_o[i]} = wake(e_tag_o_q[i], e_opnd_o_q[i],
                alu_wrt_en, alu_tag, alu_data, ls_wrt_en, ls_tag, ls_data);
            {nxt_tag_t[i], nxt_opnd_t[i]} = wake(e_tag_t_q[i], e_opnd_t_q[i],
                alu_wrt_en, alu_tag, alu_data, ls_wrt_en, ls_tag, ls_data);
            ready[i] = valid_q[i] && (nxt_tag_o[i] == TAG_FREE) &&
                       (nxt_tag_t[i] == TAG_FREE);
        end
        {a_tag_o, a_opnd_o} = wake(alloc_tag_o, alloc_opnd_o,
            alu_wrt_en, alu_tag, alu_data, ls_wrt_en, ls_tag, ls_data);
        {a_tag_t, a_opnd_t} = wake(alloc_tag_t, alloc_opnd_t,
            alu_wrt_en, alu_tag, alu_data, ls_wrt_en, ls_tag, ls_data);
        a_ready = (a_tag_o == TAG_FREE) && (a_tag_t == TAG_FREE);
    end

    // Oldest ready entry and lowest free slot
    always_comb begin
        any_ready  = 1'b0;
        sel_idx    = '0;
        sel_age    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && (!any_ready || (e_age_q[i] < sel_age))) begin
                any_ready = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = e_age_q[i];
            end
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Alloc routing: bypass only when nothing stored can issue this cycle
    always_comb begin
        bypass          = alloc_en && a_ready && !any_ready;
        store           = alloc_en && !bypass && !full_q && free_found;
        cnt_after_issue = count_q - CNT_W'(any_ready);
    end

    // Next-state for entries, status and issue outputs
    always_comb begin
        valid_d     = valid_q;
        e_age_d     = e_age_q;
        e_tag_o_d   = e_tag_o_q;
        e_tag_t_d   = e_tag_t_q;
        e_opnd_o_d  = e_opnd_o_q;
        e_opnd_t_d  = e_opnd_t_q;
        e_imm_d     = e_imm_q;
        e_op_d      = e_op_q;
        e_pc_d      = e_pc_q;
        full_d      = full_q;
        count_d     = count_q;
        work_en_d   = work_en_q;
        operand_o_d = operand_o_q;
        operand_t_d = operand_t_q;
        imm_d       = imm_q;
        op_code_d   = op_code_q;
        pc_d        = pc_q;

        if (rdy) begin
            if (flush) begin
                valid_d     = '0;
                count_d     = '0;
                full_d      = 1'b0;
                work_en_d   = 1'b0;
                operand_o_d = '0;
                operand_t_d = '0;
                imm_d       = '0;
                op_code_d   = NOP_OP;
                pc_d        = '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    e_tag_o_d[i]  = nxt_tag_o[i];
                    e_tag_t_d[i]  = nxt_tag_t[i];
                    e_opnd_o_d[i] = nxt_opnd_o[i];
                    e_opnd_t_d[i] = nxt_opnd_t[i];
                    if (any_ready && valid_q[i] && (e_age_q[i] > sel_age)) begin
                        e_age_d[i] = e_age_q[i] - IDX_W'(1);
                    end
                end

                if (any_ready) begin
                    valid_d[sel_idx] = 1'b0;
                end

                if (store) begin
                    valid_d[free_idx]    = 1'b1;
                    e_age_d[free_idx]    = IDX_W'(cnt_after_issue);
                    e_tag_o_d[free_idx]  = a_tag_o;
                    e_tag_t_d[free_idx]  = a_tag_t;
                    e_opnd_o_d[free_idx] = a_opnd_o;
                    e_opnd_t_d[free_idx] = a_opnd_t;
                    e_imm_d[free_idx]    = alloc_imm;
                    e_op_d[free_idx]     = alloc_op;
                    e_pc_d[free_idx]     = alloc_pc;
                end

                count_d = cnt_after_issue + CNT_W'(store);
                full_d  = (count_d == CNT_W'(DEPTH));

                if (any_ready) begin
                    work_en_d   = 1'b1;
                    operand_o_d = nxt_opnd_o[sel_idx];
                    operand_t_d = nxt_opnd_t[sel_idx];
                    imm_d       = e_imm_q[sel_idx];
                    op_code_d   = e_op_q[sel_idx];
                    pc_d        = e_pc_q[sel_idx];
                end else if (bypass) begin
                    work_en_d   = 1'b1;
                    operand_o_d = a_opnd_o;
                    operand_t_d = a_opnd_t;
                    imm_d       = alloc_imm;
                    op_code_d   = alloc_op;
                    pc_d        = alloc_pc;
                end else begin
                    work_en_d   = 1'b0;
                    operand_o_d = '0;
                    operand_t_d = '0;
                    imm_d       = '0;
                    op_code_d   = NOP_OP;
                    pc_d        = '0;
                end
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            e_age_q     <= '0;
            e_tag_o_q   <= '0;
            e_tag_t_q   <= '0;
            e_opnd_o_q  <= '0;
            e_opnd_t_q  <= '0;
            e_imm_q     <= '0;
            e_op_q      <= '0;
            e_pc_q      <= '0;
            full_q      <= 1'b0;
            count_q     <= '0;
            work_en_q   <= 1'b0;
            operand_o_q <= '0;
            operand_t_q <= '0;
            imm_q       <= '0;
            op_code_q   <= NOP_OP;
            pc_q        <= '0;
        end else begin
            valid_q     <= valid_d;
            e_age_q     <= e_age_d;
            e_tag_o_q   <= e_tag_o_d;
            e_tag_t_q   <= e_tag_t_d;
            e_opnd_o_q  <= e_opnd_o_d;
            e_opnd_t_q  <= e_opnd_t_d;
            e_imm_q     <= e_imm_d;
            e_op_q      <= e_op_d;
            e_pc_q      <= e_pc_d;
            full_q      <= full_d;
            count_q     <= count_d;
            work_en_q   <= work_en_d;
            operand_o_q <= operand_o_d;
            operand_t_q <= operand_t_d;
            imm_q       <= imm_d;
            op_code_q   <= op_code_d;
            pc_q        <= pc_d;
        end
    end

    assign full      = full_q;
    assign count     = count_q;
    assign work_en   = work_en_q;
    assign operand_o = operand_o_q;
    assign operand_t = operand_t_q;
    assign imm       = imm_q;
    assign op_code   = op_code_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_branch_rs_multi.sv
// Directed bench for branch_rs_multi (DEPTH=4): one table row per clock cycle,
// plus hand-written reset sequences.
module tb_branch_rs_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic        flush = 1'b0;
    logic        alu_wrt_en = 1'b0;
    logic [3:0]  alu_tag = '0;
    logic [31:0] alu_data = '0;
    logic        ls_wrt_en = 1'b0;
    logic [3:0]  ls_tag = '0;
    logic [31:0] ls_data = '0;
    logic        alloc_en = 1'b0;
    logic [31:0] alloc_opnd_o = '0;
    logic [31:0] alloc_opnd_t = '0;
    logic [3:0]  alloc_tag_o = '0;
    logic [3:0]  alloc_tag_t = '0;
    logic [5:0]  alloc_op = '0;
    logic [31:0] alloc_imm = '0;
    logic [31:0] alloc_pc = '0;
    logic        full;
    logic [2:0]  count;
    logic        work_en;
    logic [31:0] operand_o, operand_t, imm, pc;
    logic [5:0]  op_code;

    int errors = 0;
    int checks = 0;

    branch_rs_multi dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .alu_wrt_en(alu_wrt_en), .alu_tag(alu_tag), .alu_data(alu_data),
        .ls_wrt_en(ls_wrt_en), .ls_tag(ls_tag), .ls_data(ls_data),
        .alloc_en(alloc_en), .alloc_opnd_o(alloc_opnd_o), .alloc_opnd_t(alloc_opnd_t),
        .alloc_tag_o(alloc_tag_o), .alloc_tag_t(alloc_tag_t), .alloc_op(alloc_op),
        .alloc_imm(alloc_imm), .alloc_pc(alloc_pc),
        .full(full), .count(count), .work_en(work_en),
        .operand_o(operand_o), .operand_t(operand_t), .imm(imm),
        .op_code(op_code), .pc(pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, flush, a_en;
        logic [3:0]  a_tag_o, a_tag_t;
        logic [31:0] a_o, a_t, a_pc;
        logic        alu_en;
        logic [3:0]  alu_tg;
        logic [31:0] alu_d;
        logic        ls_en;
        logic [3:0]  ls_tg;
        logic [31:0] ls_d;
        logic        e_we;
        logic [31:0] e_o, e_t, e_pc;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic f, input logic ae,
        input logic [3:0] to, input logic [3:0] tt,
        input logic [31:0] ao, input logic [31:0] at, input logic [31:0] apc,
        input logic ue, input logic [3:0] ut, input logic [31:0] ud,
        input logic le, input logic [3:0] lt, input logic [31:0] ld,
        input logic we, input logic [31:0] eo, input logic [31:0] et,
        input logic [31:0] epc, input logic [2:0] ecnt);
        vec_t v;
        v.rdy = r; v.flush = f; v.a_en = ae; v.a_tag_o = to; v.a_tag_t = tt;
        v.a_o = ao; v.a_t = at; v.a_pc = apc;
        v.alu_en = ue; v.alu_tg = ut; v.alu_d = ud;
        v.ls_en = le; v.ls_tg = lt; v.ls_d = ld;
        v.e_we = we; v.e_o = eo; v.e_t = et; v.e_pc = epc; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected op/imm are derived from the expected PC the same way the
    // stimulus derives them from alloc_pc.
    task automatic check_outputs(input string tag, input logic we, input logic [31:0] eo,
                                 input logic [31:0] et, input logic [31:0] epc,
                                 input logic [2:0] ecnt);
        logic [31:0] e_imm;
        logic [5:0]  e_op;
        e_imm = we ? (epc + 32'h1000) : 32'h0;
        e_op  = we ? epc[7:2] : 6'h0;
        chk({tag, ".work_en"},   {31'h0, work_en}, {31'h0, we});
        chk({tag, ".operand_o"}, operand_o, eo);
        chk({tag, ".operand_t"}, operand_t, et);
        chk({tag, ".pc"},        pc, epc);
        chk({tag, ".imm"},       imm, e_imm);
        chk({tag, ".op_code"},   {26'h0, op_code}, {26'h0, e_op});
        chk({tag, ".count"},     {29'h0, count}, {29'h0, ecnt});
        chk({tag, ".full"},      {31'h0, full}, {31'h0, (ecnt == 3'd4)});
    endtask

    task automatic drive(input vec_t v);
        rdy          = v.rdy;
        flush        = v.flush;
        alloc_en     = v.a_en;
        alloc_tag_o  = v.a_tag_o;
        alloc_tag_t  = v.a_tag_t;
        alloc_opnd_o = v.a_o;
        alloc_opnd_t = v.a_t;
        alloc_pc     = v.a_pc;
        alloc_op     = v.a_pc[7:2];
        alloc_imm    = v.a_pc + 32'h1000;
        alu_wrt_en   = v.alu_en;
        alu_tag      = v.alu_tg;
        alu_data     = v.alu_d;
        ls_wrt_en    = v.ls_en;
        ls_tag       = v.ls_tg;
        ls_data      = v.ls_d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t idle;
        idle = mk(1,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0);

        // Bypass from empty
        vecs.push_back(mk(1,0,1, 0,0, 5,7,'h100, 0,0,0, 0,0,0, 1,5,7,'h100,0));
        vecs.push_back(idle);
        // A waits tag3, B waits tag4; tag4 broadcast issues B
        vecs.push_back(mk(1,0,1, 3,0, 1,2,'h200, 0,0,0, 0,0,0, 0,0,0,0,1));
        vecs.push_back(mk(1,0,1, 4,0, 3,4,'h204, 0,0,0, 0,0,0, 0,0,0,0,2));
        vecs.push_back(mk(1,0,0, 0,0, 0,0,0, 1,4,9, 0,0,0, 1,9,4,'h204,1));
        vecs.push_back(mk(1,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,1));
        // A wakes while ready C allocs: A issues, C stored, C issues next
        vecs.push_back(mk(1,0,1, 0,0, 8,9,'h210, 1,3,'h33, 0,0,0, 1,'h33,2,'h200,1));
        vecs.push_back(mk(1,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 1,8,9,'h210,0));
        vecs.push_back(idle);
        // Fill four entries waiting on tag2
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1,0,1, 2,0, 1,32'h30+k,32'h300+4*k, 0,0,0, 0,0,0,
                              0,0,0,0,3'(k+1)));
        // Full: non-ready alloc dropped, ready alloc bypasses
        vecs.push_back(mk(1,0,1, 5,0, 0,0,'h3E0, 0,0,0, 0,0,0, 0,0,0,0,4));
        vecs.push_back(mk(1,0,1, 0,0, 'h11,'h22,'h3F0, 0,0,0, 0,0,0, 1,'h11,'h22,'h3F0,4));
        // rdy low: everything holds, broadcast lost
        vecs.push_back(mk(0,0,0, 0,0, 0,0,0, 0,0,0, 1,2,'h77, 1,'h11,'h22,'h3F0,4));
        vecs.push_back(mk(1,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0,4));
        // LS broadcast resolves all; issue in alloc order
        vecs.push_back(mk(1,0,0, 0,0, 0,0,0, 0,0,0, 1,2,'h55, 1,'h55,'h30,'h300,3));
        vecs.push_back(mk(1,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 1,'h55,'h31,'h304,2));
        vecs.push_back(mk(1,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 1,'h55,'h32,'h308,1));
        vecs.push_back(mk(1,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0, 1,'h55,'h33,'h30C,0));
        vecs.push_back(idle);
        // Same-cycle alloc wakeup, ALU beats LS; LS wakes operand_t
        vecs.push_back(mk(1,0,1, 6,0, 'hDEAD,3,'h400, 1,6,'hAA, 1,6,'hBB, 1,'hAA,3,'h400,0));
        vecs.push_back(mk(1,0,1, 0,9, 1,0,'h404, 0,0,0, 1,9,'hBB, 1,1,'hBB,'h404,0));
        // Three waiting entries, then flush with a bypass-able alloc
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1,0,1, 7,0, 0,0,32'h500+4*k, 0,0,0, 0,0,0, 0,0,0,0,3'(k+1)));
        vecs.push_back(mk(1,1,1, 0,0, 1,2,'h50C, 0,0,0, 0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,0,0, 0,0, 0,0,0, 1,7,'h77, 0,0,0, 0,0,0,0,0));
        vecs.push_back(idle);
        vecs.push_back(mk(1,0,1, 0,0, 4,5,'h600, 0,0,0, 0,0,0, 1,4,5,'h600,0));

        // Reset state
        #3;
        check_outputs("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[n]) begin
            string tag;
            tag = $sformatf("vec%0d", n);
            drive(vecs[n]);
            @(posedge clk);
            #1;
            check_outputs(tag, vecs[n].e_we, vecs[n].e_o, vecs[n].e_t,
                          vecs[n].e_pc, vecs[n].e_cnt);
        end

        // Asynchronous reset mid-operation
        drive(mk(1,0,1, 8,0, 0,0,'h700, 0,0,0, 0,0,0, 0,0,0,0,0));
        @(posedge clk);
        #1;
        check_outputs("arst_pre0", 0, 0, 0, 0, 1);
        drive(mk(1,0,1, 0,0, 1,2,'h704, 0,0,0, 0,0,0, 0,0,0,0,0));
        @(posedge clk);
        #1;
        check_outputs("arst_pre1", 1, 1, 2, 'h704, 1);
        drive(idle);
        #2;
        rst = 1'b1;
        #1;
        check_outputs("arst_now", 0, 0, 0, 0, 0);
        rst = 1'b0;
        drive(mk(1,0,0, 0,0, 0,0,0, 1,8,'h88, 0,0,0, 0,0,0,0,0));
        @(posedge clk);
        #1;
        check_outputs("arst_post", 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
